// File: rtl/nco_sweep_ctrl.sv
// Linear phase-increment sweep generator feeding the NCO; optional NCO_SWEEP_CNT_EN adds a completed-sweep counter.
// Registered outputs: start at edge N gives f_start at edge N+1. There is no backpressure; abort always wins.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int DWW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           continuous,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_stop,
  input  logic [APR-1:0] f_step,
  input  logic [DWW-1:0] dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           step_stb,
  output logic           busy,
  output logic           done
`ifdef NCO_SWEEP_CNT_EN
  ,
  output logic [15:0]    sweep_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [APR-1:0] r_phi, w_phi_nxt;
  logic [DWW-1:0] r_cnt, w_cnt_nxt;
  logic [APR-1:0] r_cfg_start, r_cfg_stop, r_cfg_step;
  logic [DWW-1:0] r_cfg_dwell;
  logic           r_cfg_cont, r_cfg_up;
  logic           r_stb, r_busy, r_done;
  logic           w_stb_nxt, w_busy_nxt, w_done_nxt, w_load;

  logic [APR:0]   w_sum, w_dif;
  logic [APR-1:0] w_step_val;
  logic           w_cnt_zero, w_at_stop;

  // One extra bit so overshoot past f_stop (or below zero) is visible and clamped, never wrapped.
  assign w_sum      = {1'b0, r_phi} + {1'b0, r_cfg_step};
  assign w_dif      = {1'b0, r_phi} - {1'b0, r_cfg_step};
  assign w_cnt_zero = (r_cnt == '0);
  assign w_at_stop  = (r_phi == r_cfg_stop);

  always_comb begin
    w_step_val = r_cfg_stop;
    if (r_cfg_step == '0)
      w_step_val = r_cfg_stop;
    else if (r_cfg_up)
      w_step_val = (w_sum > {1'b0, r_cfg_stop}) ? r_cfg_stop : w_sum[APR-1:0];
    else
      w_step_val = (w_dif[APR] || (w_dif[APR-1:0] < r_cfg_stop)) ? r_cfg_stop : w_dif[APR-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phi_nxt   = r_phi;
    w_cnt_nxt   = r_cnt;
    w_stb_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DWELL;
          w_phi_nxt   = f_start;
          w_cnt_nxt   = dwell;
          w_stb_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_DWELL: begin
        w_busy_nxt = 1'b1;
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - DWW'(1);
        end else if (!w_at_stop) begin
          w_phi_nxt = w_step_val;
          w_cnt_nxt = r_cfg_dwell;
          w_stb_nxt = 1'b1;
        end else if (r_cfg_cont) begin
          w_phi_nxt = r_cfg_start;
          w_cnt_nxt = r_cfg_dwell;
          w_stb_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_phi_nxt   = r_phi;
      w_cnt_nxt   = r_cnt;
      w_stb_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phi       <= '0;
      r_cnt       <= '0;
      r_stb       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_start <= '0;
      r_cfg_stop  <= '0;
      r_cfg_step  <= '0;
      r_cfg_dwell <= '0;
      r_cfg_cont  <= 1'b0;
      r_cfg_up    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phi   <= w_phi_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_cfg_start <= f_start;
        r_cfg_stop  <= f_stop;
        r_cfg_step  <= f_step;
        r_cfg_dwell <= dwell;
        r_cfg_cont  <= continuous;
        r_cfg_up    <= (f_stop >= f_start);
      end
    end
  end

  assign phi_inc_o = r_phi;
  assign step_stb  = r_stb;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef NCO_SWEEP_CNT_EN
  logic        w_cmp;
  logic [15:0] r_sweep_cnt;

  // A sweep counts once the final f_stop value has served its full dwell.
  assign w_cmp = (r_state == S_DWELL) && w_cnt_zero && w_at_stop && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sweep_cnt <= '0;
    else if (w_load)
      r_sweep_cnt <= '0;
    else if (w_cmp)
      r_sweep_cnt <= r_sweep_cnt + 16'd1;
  end

  assign sweep_cnt = r_sweep_cnt;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected increments are queued at start, popped on each step_stb.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, continuous;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] phi_inc_o;
  logic        step_stb, busy, done;
`ifdef NCO_SWEEP_CNT_EN
  logic [15:0] sweep_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_exp[$];
  logic [31:0] q_obs[$];
  int          q_cyc[$];
  int          busy_cnt, done_cnt, done_cyc;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.APR(32), .DWW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .f_start    (f_start),
    .f_stop     (f_stop),
    .f_step     (f_step),
    .dwell      (dwell),
    .phi_inc_o  (phi_inc_o),
    .step_stb   (step_stb),
    .busy       (busy),
    .done       (done)
`ifdef NCO_SWEEP_CNT_EN
    ,
    .sweep_cnt  (sweep_cnt)
`endif
  );

  // Reference sequence of one pass from fs to fe, clamped at fe.
  function automatic void push_pass(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st);
    logic [31:0] v;
    logic [32:0] t;
    v = fs;
    q_exp.push_back(v);
    while (v != fe) begin
      if (st == 32'd0) begin
        v = fe;
      end else if (fe >= fs) begin
        t = {1'b0, v} + {1'b0, st};
        v = (t > {1'b0, fe}) ? fe : t[31:0];
      end else begin
        v = ((st > v) || ((v - st) < fe)) ? fe : (v - st);
      end
      q_exp.push_back(v);
    end
  endfunction

  task automatic kick(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                      input logic [15:0] dw, input logic cont);
    @(negedge clk);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; continuous = cont;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records strobes and status for ncyc cycles; optionally pulses start with a new config at inj_c.
  task automatic observe(input int ncyc, input int inj_c);
    q_obs.delete(); q_cyc.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (step_stb) begin q_obs.push_back(phi_inc_o); q_cyc.push_back(c); end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      start = (c == inj_c);
      if (c == inj_c) begin
        f_start = 32'd500; f_stop = 32'd600; f_step = 32'd1; dwell = 16'd0; continuous = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({phi_inc_o, step_stb, busy, done} !== 35'd0) begin
      n_err++; $display("FAIL reset_init: got %h/%b/%b/%b want 0", phi_inc_o, step_stb, busy, done);
    end
`ifdef NCO_SWEEP_CNT_EN
    n_vec++;
    if (sweep_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", sweep_cnt); end
`endif
    reset = 1'b0;
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({phi_inc_o, step_stb, busy, done} !== 35'd0) begin
      n_err++; $display("FAIL reset_async: got %h/%b/%b/%b want 0", phi_inc_o, step_stb, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [31:0] t_fs[5], t_fe[5], t_st[5];
    logic [15:0] t_dw[5];
    logic [31:0] e, o;
    int n, hold;
    t_fs = '{32'd100, 32'd50, 32'hFFFF_FFF0, 32'd8,   32'd42};
    t_fe = '{32'd130, 32'd7,  32'hFFFF_FFFF, 32'd200, 32'd42};
    t_st = '{32'd10,  32'd20, 32'h20,        32'd0,   32'd5};
    t_dw = '{16'd2,   16'd0,  16'd0,         16'd1,   16'd3};
    for (int k = 0; k < 5; k++) begin
      q_exp.delete();
      push_pass(t_fs[k], t_fe[k], t_st[k]);
      n = q_exp.size();
      hold = int'(t_dw[k]) + 1;
      kick(t_fs[k], t_fe[k], t_st[k], t_dw[k], 1'b0);
      observe(40, -1);
      n_vec++;
      if (q_obs.size() !== n) begin n_err++; $display("FAIL os%0d_count: got %0d want %0d", k, q_obs.size(), n); end
      n_vec++;
      if (q_cyc.size() > 0 && q_cyc[0] !== 0) begin n_err++; $display("FAIL os%0d_latency: got %0d want 0", k, q_cyc[0]); end
      for (int i = 1; i < q_cyc.size(); i++) begin
        n_vec++;
        if (q_cyc[i] - q_cyc[i-1] !== hold) begin
          n_err++; $display("FAIL os%0d_gap%0d: got %0d want %0d", k, i, q_cyc[i] - q_cyc[i-1], hold);
        end
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
        e = q_exp.pop_front(); o = q_obs.pop_front();
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL os%0d_value: got %h want %h", k, o, e); end
      end
      n_vec++;
      if (busy_cnt !== n * hold) begin n_err++; $display("FAIL os%0d_busy: got %0d want %0d", k, busy_cnt, n * hold); end
      n_vec++;
      if (done_cnt !== 1 || done_cyc !== n * hold) begin
        n_err++; $display("FAIL os%0d_done: got %0d at %0d want 1 at %0d", k, done_cnt, done_cyc, n * hold);
      end
      n_vec++;
      if (phi_inc_o !== t_fe[k]) begin n_err++; $display("FAIL os%0d_final: got %h want %h", k, phi_inc_o, t_fe[k]); end
`ifdef NCO_SWEEP_CNT_EN
      n_vec++;
      if (sweep_cnt !== 16'd1) begin n_err++; $display("FAIL os%0d_sweep_cnt: got %0d want 1", k, sweep_cnt); end
`endif
    end
  endtask

  task automatic test_continuous();
    logic [31:0] e, o;
    q_exp.delete();
    repeat (3) push_pass(32'd1, 32'd3, 32'd1);
    kick(32'd1, 32'd3, 32'd1, 16'd1, 1'b1);
    observe(14, -1);
    n_vec++;
    if (q_obs.size() !== 7) begin n_err++; $display("FAIL cont_count: got %0d want 7", q_obs.size()); end
    for (int i = 1; i < q_cyc.size(); i++) begin
      n_vec++;
      if (q_cyc[i] - q_cyc[i-1] !== 2) begin n_err++; $display("FAIL cont_gap%0d: got %0d want 2", i, q_cyc[i] - q_cyc[i-1]); end
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL cont_value: got %h want %h", o, e); end
    end
    n_vec++;
    if (done_cnt !== 0 || busy_cnt !== 14) begin
      n_err++; $display("FAIL cont_status: got done %0d busy %0d want 0 and 14", done_cnt, busy_cnt);
    end
`ifdef NCO_SWEEP_CNT_EN
    n_vec++;
    if (sweep_cnt !== 16'd2) begin n_err++; $display("FAIL cont_sweep_cnt: got %0d want 2", sweep_cnt); end
`endif
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || step_stb !== 1'b0) begin n_err++; $display("FAIL cont_abort: got busy %b stb %b want 0 0", busy, step_stb); end
`ifdef NCO_SWEEP_CNT_EN
    n_vec++;
    if (sweep_cnt !== 16'd2) begin n_err++; $display("FAIL cont_cnt_hold: got %0d want 2", sweep_cnt); end
`endif
    observe(10, -1);
    n_vec++;
    if (q_obs.size() !== 0 || done_cnt !== 0) begin
      n_err++; $display("FAIL cont_idle: got %0d strobes %0d done want 0 0", q_obs.size(), done_cnt);
    end
  endtask

  task automatic test_abort();
    logic [31:0] held;
    q_exp.delete();
    push_pass(32'd100, 32'd130, 32'd10);
    held = q_exp[1];
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || step_stb !== 1'b0) begin n_err++; $display("FAIL abort_busy: got busy %b stb %b want 0 0", busy, step_stb); end
    n_vec++;
    if (phi_inc_o !== held) begin n_err++; $display("FAIL abort_hold: got %0d want %0d", phi_inc_o, held); end
    observe(20, -1);
    n_vec++;
    if (done_cnt !== 0 || q_obs.size() !== 0 || busy_cnt !== 0) begin
      n_err++; $display("FAIL abort_quiet: got done %0d strobes %0d busy %0d want 0", done_cnt, q_obs.size(), busy_cnt);
    end
    f_start = 32'd77; f_stop = 32'd90; f_step = 32'd1; dwell = 16'd0; continuous = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || step_stb !== 1'b0 || phi_inc_o !== held) begin
      n_err++; $display("FAIL abort_vs_start: got busy %b stb %b phi %0d want 0 0 %0d", busy, step_stb, phi_inc_o, held);
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] e, o;
    q_exp.delete();
    push_pass(32'd100, 32'd130, 32'd10);
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    observe(30, 4);
    n_vec++;
    if (q_obs.size() !== 4) begin n_err++; $display("FAIL busy_start_count: got %0d want 4", q_obs.size()); end
    for (int i = 1; i < q_cyc.size(); i++) begin
      n_vec++;
      if (q_cyc[i] - q_cyc[i-1] !== 3) begin n_err++; $display("FAIL busy_start_gap%0d: got %0d want 3", i, q_cyc[i] - q_cyc[i-1]); end
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front();
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL busy_start_value: got %0d want %0d", o, e); end
    end
    n_vec++;
    if (done_cnt !== 1 || busy_cnt !== 12 || phi_inc_o !== 32'd130) begin
      n_err++; $display("FAIL busy_start_end: got done %0d busy %0d phi %0d want 1 12 130", done_cnt, busy_cnt, phi_inc_o);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    test_reset();
    test_oneshot();
    test_continuous();
    test_abort();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
